// File: rtl/wb_daq_channel_dma_if.sv
// Wishbone classic write bus between the DAQ channel DMA (master) and memory (slave).
interface wb_daq_channel_dma_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0] wb_m_adr_o;
    logic [dw-1:0] wb_m_dat_o;
    logic [3:0]    wb_m_sel_o;
    logic          wb_m_we_o;
    logic          wb_m_cyc_o;
    logic          wb_m_stb_o;
    logic          wb_m_ack_i;
    logic          wb_m_err_i;

    modport master (
        output wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
        input  wb_m_ack_i, wb_m_err_i
    );

    modport slave (
        input  wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
        output wb_m_ack_i, wb_m_err_i
    );
endinterface

// File: rtl/wb_daq_channel_dma.sv
// DAQ channel DMA: buffers front-end samples in a small FIFO and writes them
// word by word to a memory buffer through a Wishbone classic master port.
module wb_daq_channel_dma #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int FIFO_AW = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [31:0]          daq_channel_control_reg,
    input  logic [31:0]          daq_channel_address_reg,
    output logic [31:0]          daq_channel_status_reg,
    input  logic [dw-1:0]        sample_data,
    input  logic                 sample_valid,
    wb_daq_channel_dma_if.master wb_m,
    output logic                 interrupt
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE, S_ERROR} state_t;

    logic          enable, continuous, irq_en;
    logic [15:0]   length;
    logic [aw-1:0] base_addr;
    logic          unused_ctrl;

    assign enable      = daq_channel_control_reg[0];
    assign continuous  = daq_channel_control_reg[1];
    assign irq_en      = daq_channel_control_reg[2];
    assign length      = daq_channel_control_reg[31:16];
    assign base_addr   = aw'(daq_channel_address_reg);
    assign unused_ctrl = ^daq_channel_control_reg[15:3];

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [aw-1:0]      cur_addr_q, cur_addr_d;
    logic [dw-1:0]      dat_q, dat_d;
    logic               cyc_q, cyc_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        words_q, words_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               berr_q, berr_d;
    logic               irq_q, irq_d;
    logic [31:0]        status_q, status_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [dw-1:0]      mem [DEPTH];

    logic       fifo_full, fifo_empty;
    logic       push, pop, flush;
    logic [3:0] level_sat;

    assign fifo_full  = (level_q == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign level_sat  = (32'(level_q) > 32'd15) ? 4'hF : 4'(level_q);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        en_d       = enable;
        cur_addr_d = cur_addr_q;
        dat_d      = dat_q;
        cyc_d      = cyc_q;
        count_d    = count_q;
        words_d    = words_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        berr_d     = berr_q;
        irq_d      = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable && !en_q) begin
                    cur_addr_d = base_addr;
                    count_d    = '0;
                    words_d    = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    berr_d     = 1'b0;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        irq_d   = irq_en;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    dat_d   = mem[rd_ptr_q];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // First WRITE cycle is bus setup; the strobe rises one edge after the pop.
                if (!cyc_q) begin
                    if (!enable) state_d = S_IDLE;
                    else         cyc_d   = 1'b1;
                end else if (wb_m.wb_m_err_i) begin
                    cyc_d   = 1'b0;
                    berr_d  = 1'b1;
                    irq_d   = irq_en;
                    state_d = enable ? S_ERROR : S_IDLE;
                end else if (wb_m.wb_m_ack_i) begin
                    cyc_d      = 1'b0;
                    cur_addr_d = cur_addr_q + aw'(4);
                    count_d    = count_q + 16'd1;
                    words_d    = words_q + 16'd1;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (count_q + 16'd1 == length) begin
                        irq_d = irq_en;
                        if (continuous) begin
                            cur_addr_d = base_addr;
                            count_d    = '0;
                            state_d    = S_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        flush = (state_d == S_IDLE) && (state_q != S_IDLE);
        push  = sample_valid && enable && (!fifo_full || pop);
        if (sample_valid && enable && fifo_full && !pop) ovf_d = 1'b1;

        wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        level_d  = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        status_d = {words_q, 8'h00, level_sat, berr_q, ovf_q, done_q,
                    (state_q == S_WAIT) || (state_q == S_WRITE)};
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            cur_addr_q <= '0;
            dat_q      <= '0;
            cyc_q      <= 1'b0;
            count_q    <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            berr_q     <= 1'b0;
            irq_q      <= 1'b0;
            status_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cur_addr_q <= cur_addr_d;
            dat_q      <= dat_d;
            cyc_q      <= cyc_d;
            count_q    <= count_d;
            words_q    <= words_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            berr_q     <= berr_d;
            irq_q      <= irq_d;
            status_q   <= status_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr_q] <= sample_data;
    end

    assign wb_m.wb_m_adr_o = cur_addr_q;
    assign wb_m.wb_m_dat_o = dat_q;
    assign wb_m.wb_m_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wb_m.wb_m_we_o  = cyc_q;
    assign wb_m.wb_m_cyc_o = cyc_q;
    assign wb_m.wb_m_stb_o = cyc_q;

    assign interrupt              = irq_q;
    assign daq_channel_status_reg = status_q;
endmodule

// File: tb/tb_wb_daq_channel_dma.sv
// Self-checking bench for wb_daq_channel_dma: table-driven directed runs, an
// overflow stall, randomized runs against a word-list model, and async reset.
module tb_wb_daq_channel_dma;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ctrl, base_reg, sdata, status;
    logic        svalid, irq;

    wb_daq_channel_dma_if bus ();

    wb_daq_channel_dma dut (
        .wb_clk                  (clk),
        .wb_rst_n                (rst_n),
        .daq_channel_control_reg (ctrl),
        .daq_channel_address_reg (base_reg),
        .daq_channel_status_reg  (status),
        .sample_data             (sdata),
        .sample_valid            (svalid),
        .wb_m                    (bus),
        .interrupt               (irq)
    );

    int checks   = 0;
    int failures = 0;

    int wait_states = 0;
    int err_at      = 0;
    int write_idx   = 0;
    int term_cnt    = 0;
    int wcnt        = 0;
    int irq_cnt     = 0;
    int stb_cnt     = 0;
    logic        stb_prev;
    logic [31:0] adr_log[$];
    logic [31:0] dat_log[$];
    logic [31:0] stim_q[$];

    typedef struct {
        string       name;
        logic [31:0] ctrl;
        logic [31:0] base;
        int          n;
        logic [31:0] dbase;
        int          wait_st;
        int          err_at;
        int          words;
        bit          done;
        bit          berr;
        int          irqs;
        int          level;
        bit          busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wishbone slave: terminates each strobe after wait_states idle samples; the
    // err_at-th termination is an error, the others are acks that log the write.
    initial begin
        bus.wb_m_ack_i = 1'b0;
        bus.wb_m_err_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wb_m_ack_i || bus.wb_m_err_i) begin
                bus.wb_m_ack_i = 1'b0;
                bus.wb_m_err_i = 1'b0;
                wcnt = 0;
            end else if (bus.wb_m_stb_o && rst_n) begin
                wcnt++;
                if (wcnt > wait_states) begin
                    wcnt = 0;
                    write_idx++;
                    term_cnt++;
                    if (write_idx == err_at) begin
                        bus.wb_m_err_i = 1'b1;
                    end else begin
                        bus.wb_m_ack_i = 1'b1;
                        adr_log.push_back(bus.wb_m_adr_o);
                        dat_log.push_back(bus.wb_m_dat_o);
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        stb_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (irq) irq_cnt++;
            if (bus.wb_m_stb_o && !stb_prev) stb_cnt++;
            stb_prev = bus.wb_m_stb_o;
        end
    end

    task automatic prep(input logic [31:0] c, input logic [31:0] b, input int ws, input int ea);
        ctrl        = c & ~32'h1;
        base_reg    = b;
        wait_states = ws;
        err_at      = ea;
        repeat (3) @(negedge clk);
        adr_log.delete();
        dat_log.delete();
        irq_cnt   = 0;
        stb_cnt   = 0;
        term_cnt  = 0;
        write_idx = 0;
        ctrl      = c;
    endtask

    task automatic send_samples(input int gap_max);
        foreach (stim_q[k]) begin
            sdata  = stim_q[k];
            svalid = 1'b1;
            @(negedge clk);
            svalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        svalid = 1'b0;
    endtask

    task automatic wait_terms(input string nm, input int target);
        int n = 0;
        while ((term_cnt < target || bus.wb_m_cyc_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_in_time"}, 32'(n < 1000), 32'd1);
        repeat (8) @(negedge clk);
    endtask

    // Reference: write k carries sample k to base + 4*(k mod LENGTH), wrapping at 2^32.
    task automatic check_writes(input string nm, input logic [31:0] b, input int len, input int n);
        check({nm, "_nwrites"}, adr_log.size(), n);
        for (int k = 0; k < n && k < adr_log.size(); k++) begin
            check($sformatf("%s_adr%0d", nm, k), adr_log[k], b + 32'(4 * (k % len)));
            check($sformatf("%s_dat%0d", nm, k), dat_log[k], stim_q[k]);
        end
    endtask

    task automatic disable_and_check(input string nm, input logic [31:0] c);
        ctrl = c & ~32'h1;
        repeat (4) @(negedge clk);
        check({nm, "_flush_level"}, status[7:4], 4'd0);
        check({nm, "_idle_busy"}, status[0], 1'b0);
    endtask

    task automatic run_case(input string nm, input logic [31:0] c, input logic [31:0] b,
                            input int gap_max, input int ws, input int ea, input int e_words,
                            input bit e_done, input bit e_berr, input int e_irq,
                            input int e_level, input bit e_busy);
        prep(c, b, ws, ea);
        send_samples(gap_max);
        wait_terms(nm, e_words + (e_berr ? 1 : 0));
        check_writes(nm, b, int'(c[31:16]), e_words);
        check({nm, "_busy"}, status[0], e_busy);
        check({nm, "_done"}, status[1], e_done);
        check({nm, "_ovf"}, status[2], 1'b0);
        check({nm, "_berr"}, status[3], e_berr);
        check({nm, "_level"}, status[7:4], e_level);
        check({nm, "_words"}, status[31:16], e_words);
        check({nm, "_irqs"}, irq_cnt, e_irq);
        check({nm, "_stbs"}, stb_cnt, e_words + (e_berr ? 1 : 0));
        disable_and_check(nm, c);
    endtask

    initial begin
        int n, l, ntx, cyc_cnt;
        bit cont;
        logic [31:0] b, c;

        ctrl     = '0;
        base_reg = '0;
        sdata    = '0;
        svalid   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_cyc", bus.wb_m_cyc_o, 1'b0);
        check("reset_stb", bus.wb_m_stb_o, 1'b0);
        check("reset_status", status, 32'h0);
        check("reset_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        //          name        ctrl          base          n  dbase  ws ea wrd dn be irq lvl busy
        vecs[0] = '{"basic",    32'h0004_0005, 32'h0000_1000, 4, 32'hA0, 1, 0, 4, 1, 0, 1, 0, 0};
        vecs[1] = '{"buserr",   32'h0004_0005, 32'h0000_3000, 4, 32'h10, 0, 2, 1, 0, 1, 1, 2, 0};
        vecs[2] = '{"contin",   32'h0002_0007, 32'h0000_2000, 5, 32'h50, 0, 0, 5, 0, 0, 2, 0, 1};
        vecs[3] = '{"wrap",     32'h0003_0005, 32'hFFFF_FFF8, 3, 32'h70, 2, 0, 3, 1, 0, 1, 0, 0};
        vecs[4] = '{"len0",     32'h0000_0005, 32'h0000_0100, 2, 32'h90, 0, 0, 0, 1, 0, 1, 2, 0};
        vecs[5] = '{"noirq",    32'h0002_0001, 32'h0000_0200, 2, 32'h60, 0, 0, 2, 1, 0, 0, 0, 0};
        vecs[6] = '{"extra",    32'h0002_0005, 32'h0000_0300, 5, 32'h30, 0, 0, 2, 1, 0, 1, 3, 0};

        for (int v = 0; v < 7; v++) begin
            stim_q.delete();
            for (int k = 0; k < vecs[v].n; k++) stim_q.push_back(vecs[v].dbase + 32'(k));
            run_case(vecs[v].name, vecs[v].ctrl, vecs[v].base, 0, vecs[v].wait_st, vecs[v].err_at,
                     vecs[v].words, vecs[v].done, vecs[v].berr, vecs[v].irqs, vecs[v].level,
                     vecs[v].busy);
        end

        // 12 back-to-back samples against a 20-cycle ack stall: one sample is already
        // on the bus, eight fill the FIFO, the last three are dropped.
        prep(32'h0010_0005, 32'h0000_4000, 20, 0);
        stim_q.delete();
        for (int k = 0; k < 12; k++) stim_q.push_back(32'hB0 + 32'(k));
        send_samples(0);
        repeat (3) @(negedge clk);
        check("ovf_mid_flag", status[2], 1'b1);
        check("ovf_mid_level", status[7:4], 4'd8);
        check("ovf_mid_nowrite", adr_log.size(), 0);
        wait_terms("ovf", 9);
        check_writes("ovf", 32'h0000_4000, 16, 9);
        check("ovf_words", status[31:16], 16'd9);
        check("ovf_sticky", status[2], 1'b1);
        check("ovf_busy", status[0], 1'b1);
        check("ovf_irqs", irq_cnt, 0);
        disable_and_check("ovf", 32'h0010_0005);

        for (int t = 0; t < 12; t++) begin
            n    = $urandom_range(1, 8);
            l    = $urandom_range(1, 6);
            cont = 1'($urandom_range(0, 1));
            b    = $urandom() & 32'hFFFF_FFFC;
            if (t % 4 == 3) b = 32'hFFFF_FFF0;
            c    = {16'(l), 13'd0, 1'b1, cont, 1'b1};
            stim_q.delete();
            for (int k = 0; k < n; k++) stim_q.push_back($urandom());
            ntx = cont ? n : ((n < l) ? n : l);
            run_case($sformatf("rnd%0d", t), c, b, 3, $urandom_range(0, 3), 0, ntx,
                     !cont && (n >= l), 1'b0, cont ? (n / l) : ((n >= l) ? 1 : 0),
                     n - ntx, !(!cont && (n >= l)));
        end

        // Asynchronous reset in the middle of a stalled write.
        prep(32'h0004_0005, 32'h0000_5000, 30, 0);
        stim_q.delete();
        stim_q.push_back(32'hC0);
        send_samples(0);
        cyc_cnt = 0;
        while (!bus.wb_m_cyc_o && cyc_cnt < 20) begin
            @(negedge clk);
            cyc_cnt++;
        end
        check("rst_reach_write", 32'(cyc_cnt < 20), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_cyc", bus.wb_m_cyc_o, 1'b0);
        check("rst_async_stb", bus.wb_m_stb_o, 1'b0);
        check("rst_async_adr", bus.wb_m_adr_o, 32'h0);
        check("rst_async_dat", bus.wb_m_dat_o, 32'h0);
        check("rst_async_status", status, 32'h0);
        check("rst_async_irq", irq, 1'b0);
        ctrl = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release_status", status, 32'h0);
        check("rst_release_cyc", bus.wb_m_cyc_o, 1'b0);
        stim_q.delete();
        stim_q.push_back(32'hD0);
        run_case("post_rst", 32'h0001_0005, 32'h0000_6000, 0, 0, 0, 1, 1, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_daq_channel_dma.md
WB_DAQ_CHANNEL_DMA -- requirements
Module: wb_daq_channel_dma

Interface
REQ-001 SHALL have parameter dw, 32, data width of samples and bus data.
REQ-002 SHALL have parameter aw, 32, Wishbone master address width.
REQ-003 SHALL have parameter FIFO_AW, 3, log2 of sample FIFO depth (default 8 entries).
REQ-004 SHALL have port wb_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port daq_channel_control_reg  input  32  [0] ENABLE, [1] CONTINUOUS, [2] IRQ_EN, [31:16] LENGTH in words.
REQ-007 SHALL have port daq_channel_address_reg  input  32  byte base address of destination buffer.
REQ-008 SHALL have port daq_channel_status_reg  output  32  [0] BUSY, [1] DONE, [2] OVERFLOW, [3] BUS_ERR, [7:4] FIFO level (saturating at 15), [31:16] words written.
REQ-009 SHALL have port sample_data  input  dw  sample from the acquisition front end.
REQ-010 SHALL have port sample_valid  input  1  one-cycle strobe qualifying sample_data; there is no backpressure.
REQ-011 SHALL have ports wb_m_adr_o (output aw), wb_m_dat_o (output dw), wb_m_sel_o (output 4), wb_m_we_o, wb_m_cyc_o and wb_m_stb_o (each output 1): the Wishbone classic master write bus.
REQ-012 SHALL have ports wb_m_ack_i and wb_m_err_i (each input 1): the Wishbone slave termination.
REQ-013 SHALL have port interrupt  output  1  one-cycle pulse on completion or error.

Function
REQ-014 Sample FIFO: SHALL push sample_data when sample_valid=1 and ENABLE=1 and (not full, or a pop occurs in the same cycle); when full with no pop, SHALL drop the sample and set OVERFLOW (sticky).
REQ-015 FSM states SHALL be IDLE, WAIT, WRITE, DONE, ERROR.
REQ-016 IDLE: on ENABLE 0->1, SHALL load cur_addr=address_reg and count=0 and go to WAIT; if LENGTH=0, SHALL go directly to DONE.
REQ-017 WAIT: when FIFO is not empty, SHALL pop the head into wb_m_dat_o, drive wb_m_adr_o=cur_addr, assert cyc/stb/we the next cycle (sel=4'hF), and go to WRITE.
REQ-018 WRITE: SHALL hold adr/dat/cyc/stb stable until ack or err; on ack, SHALL drop cyc/stb the same edge, apply cur_addr+=4 (mod 2^aw) and count+=1.
REQ-019 After ack, if count=LENGTH: with CONTINUOUS=1, SHALL reload cur_addr=address_reg and count=0, pulse interrupt (if IRQ_EN), and return to WAIT; otherwise SHALL go to DONE.
REQ-020 On err in WRITE, SHALL drop cyc/stb, set BUS_ERR, go to ERROR, and pulse interrupt if IRQ_EN; ack and err together SHALL be treated as err.
REQ-021 DONE entry SHALL set DONE and pulse interrupt if IRQ_EN; the channel SHALL stay in DONE while ENABLE=1.
REQ-022 ENABLE=0 in any state SHALL return to IDLE; in WRITE, SHALL first wait for ack/err (no bus abort), then go to IDLE.
REQ-023 Entering IDLE SHALL flush the FIFO; a new ENABLE rising edge SHALL clear DONE, OVERFLOW, BUS_ERR and words written.
REQ-024 Each cycle boundary SHALL insert at least one idle cycle between consecutive stb assertions.
REQ-025 BUSY SHALL be 1 in WAIT and WRITE; status SHALL be registered, reflecting state one cycle later.
REQ-026 Latency: a sample pushed into an empty FIFO in WAIT SHALL see stb asserted 2 cycles after the sample_valid edge.

Reset
REQ-027 wb_rst_n=0 SHALL immediately force cyc, stb, we, interrupt and status to 0, adr/dat to 0, the FIFO to empty, and the FSM to IDLE, independent of wb_clk; release SHALL be synchronous-safe (first active edge after deassertion).

Verification
REQ-028 Base=0x1000, LENGTH=4, 4 samples 0xA0..0xA3, ack after 1 wait state -> writes to 0x1000/04/08/0C with matching data; DONE=1; words written=4; one interrupt pulse.
REQ-029 12 back-to-back samples, ack stalled 20 cycles -> 8 accepted; OVERFLOW=1; FIFO level=8; no FIFO corruption on resume.
REQ-030 err on the 2nd write -> BUS_ERR=1; state ERROR; no further stb; interrupt pulse; words written=1.
REQ-031 CONTINUOUS=1, LENGTH=2, base=0x2000, 5 samples -> addresses 0x2000, 0x2004, 0x2000, 0x2004, 0x2000; 2 interrupt pulses.
REQ-032 Assert wb_rst_n=0 mid-WRITE -> cyc/stb are 0 before the next clock edge; after release, status=0 and the FSM is in IDLE.
REQ-033 Base=0xFFFFFFF8, LENGTH=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
